// File: rtl/perf_pkg.sv
// Shared constants for the branch/pipeline performance monitor: state
// encoding, default widths and the channel map used by the core integration.
package perf_pkg;

  localparam int DEF_NUM_EV = 4;
  localparam int DEF_CNT_W  = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  typedef enum logic [1:0] {
    PS_IDLE   = ST_IDLE,
    PS_RUN    = ST_RUN,
    PS_FROZEN = ST_FROZEN
  } perf_state_e;

  // Counter slots as wired by the core: slot 0 is always the cycle counter.
  localparam int CH_CYCLE  = 0;
  localparam int CH_BRANCH = 1;
  localparam int CH_MISS   = 2;
  localparam int CH_IMISS  = 3;
  localparam int CH_DMISS  = 4;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear and a sticky overflow flag;
// on overflow it either holds at all-ones or wraps, selected by SATURATE.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] value_reg;
  logic             ovf_reg;
  logic             at_max;

  assign at_max = &value_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        // A saturated counter keeps its value; a wrapping one rolls to zero.
        value_reg <= SATURATE ? value_reg : '0;
        ovf_reg   <= 1'b1;
      end else begin
        value_reg <= value_reg + CNT_W'(1);
      end
    end
  end

  assign value = value_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/branch_perf_monitor.sv
// Performance monitor: cycle counter plus NUM_EV stall-qualified event
// counters, start/freeze/clear control and a registered indexed read port.
module branch_perf_monitor
  import perf_pkg::*;
#(
  parameter int  NUM_EV   = DEF_NUM_EV,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter bit  SATURATE = 1'b1,
  localparam int IDX_W    = $clog2(NUM_EV + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              freeze,
  input  logic              clear,
  input  logic              stall,
  input  logic [NUM_EV-1:0] ev_valid,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_EV:0]   ovf,
  output logic [1:0]        state_o
);

  localparam int TBL_SIZE = 2 ** IDX_W;

  perf_state_e state_reg;
  perf_state_e state_next;
  logic        running;
  logic [NUM_EV:0]  inc_vec;
  logic [CNT_W-1:0] cnt_table [TBL_SIZE];
  logic [CNT_W-1:0] rd_data_reg;
  logic [CNT_W-1:0] rd_data_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = PS_IDLE;
    end else begin
      case (state_reg)
        PS_IDLE:   if (start) state_next = PS_RUN;
        PS_RUN:    if (freeze) state_next = PS_FROZEN;
        PS_FROZEN: state_next = PS_FROZEN;
        default:   state_next = PS_IDLE;
      endcase
    end
  end

  // The freeze edge itself is still a RUN edge, so it is counted.
  assign running    = (state_reg == PS_RUN);
  assign inc_vec[0] = running;

  generate
    for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_qual
      assign inc_vec[gi+1] = running & ev_valid[gi] & ~stall;
    end
  endgenerate

  // Unused index slots read back as zero.
  generate
    for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_cnt
      if (gi <= NUM_EV) begin : g_real
        perf_counter #(
          .CNT_W    (CNT_W),
          .SATURATE (SATURATE)
        ) u_counter (
          .clk   (clk),
          .rst   (rst),
          .clr   (clear),
          .inc   (inc_vec[gi]),
          .value (cnt_table[gi]),
          .ovf   (ovf[gi])
        );
      end else begin : g_pad
        assign cnt_table[gi] = '0;
      end
    end
  endgenerate

  assign rd_data_next = cnt_table[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign state_o = state_reg;

endmodule
